fifo_flags: RTL and testbench

Parametrised synchronous FIFO, successor to the basic fifo block, with arbitrary (non-power-of-two) depth and an exported fill level. Adds programmable almost-full/almost-empty thresholds, defined simultaneous read/write at the full and empty boundaries, and one-cycle overflow/underflow error pulses. Sits between producer and consumer in the same clock domain. Drop-in for fifo on the common ports.

---
 rtl/fifo_flags.sv | 121 ++++++++++++
 tb/tb_fifo_flags.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Synchronous FIFO with arbitrary depth, fill level, almost-full/empty thresholds and
// one-cycle overflow/underflow pulses. Define FIFO_FWFT_EN for first-word fall-through output.
module fifo_flags #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           fifo_data_in,
    input  logic                       fifo_write,
    input  logic                       fifo_read,
    output logic [WIDTH-1:0]           fifo_data_out,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       fifo_almost_full,
    output logic                       fifo_almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_overflow,
    output logic                       fifo_underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntAf   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CntAe   = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic empty, full;
    logic rd_ok, wr_ok;

    // Status is decoded from the registered count only.
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CntFull);

    // A write to a full FIFO is allowed when a read frees a slot in the same cycle.
    assign rd_ok = fifo_read && !empty;
    assign wr_ok = fifo_write && (!full || rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        overflow_d  = fifo_write && !wr_ok;
        underflow_d = fifo_read && !rd_ok;

        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= fifo_data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign fifo_data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_q, data_d;

    assign data_d = rd_ok ? mem_q[rd_ptr_q] : data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign fifo_data_out = data_q;
`endif

    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (cnt_q >= CntAf);
    assign fifo_almost_empty = (cnt_q <= CntAe);
    assign fifo_count        = cnt_q;
    assign fifo_overflow     = overflow_q;
    assign fifo_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: a DEPTH=4 instance for flag/boundary behaviour and a
// DEPTH=5 instance for ordering across pointer wrap. Follows FIFO_FWFT_EN when defined.
module tb_fifo_flags;

    logic        clk;
    logic        rst;

    logic [15:0] din4, dout4;
    logic        wr4, rd4, full4, empty4, af4, ae4, of4, uf4;
    logic [2:0]  cnt4;

    logic [15:0] din5, dout5;
    logic        wr5, rd5, full5, empty5, af5, ae5, of5, uf5;
    logic [2:0]  cnt5;

    int checks;
    int errors;

    fifo_flags #(
        .WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_dut4 (
        .clk(clk), .rst(rst),
        .fifo_data_in(din4), .fifo_write(wr4), .fifo_read(rd4),
        .fifo_data_out(dout4), .fifo_full(full4), .fifo_empty(empty4),
        .fifo_almost_full(af4), .fifo_almost_empty(ae4), .fifo_count(cnt4),
        .fifo_overflow(of4), .fifo_underflow(uf4)
    );

    fifo_flags #(
        .WIDTH(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_dut5 (
        .clk(clk), .rst(rst),
        .fifo_data_in(din5), .fifo_write(wr5), .fifo_read(rd5),
        .fifo_data_out(dout5), .fifo_full(full5), .fifo_empty(empty5),
        .fifo_almost_full(af5), .fifo_almost_empty(ae5), .fifo_count(cnt5),
        .fifo_overflow(of5), .fifo_underflow(uf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive4(input logic w, input logic r, input logic [15:0] d);
        wr4 = w; rd4 = r; din4 = d;
        @(posedge clk); #1;
        wr4 = 1'b0; rd4 = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] fl;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        fl = {full4, empty4, af4, ae4, of4, uf4};
        checks++;
        if (fl !== 6'b010100) begin
            errors++; $display("FAIL reset_flags got %b want %b", fl, 6'b010100);
        end
        checks++;
        if (cnt4 !== 3'd0 || dout4 !== 16'h0) begin
            errors++; $display("FAIL reset_cnt_data got %0d/%h want 0/0000", cnt4, dout4);
        end
        @(posedge clk); #1;
        checks++;
        if (cnt4 !== 3'd0 || empty4 !== 1'b1) begin
            errors++; $display("FAIL reset_hold got cnt %0d empty %b want 0/1", cnt4, empty4);
        end
        rst = 1'b1;
    endtask

    task automatic test_fill;
        logic [5:0] fl, ex;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 1'b0, 16'(5 - i));
            fl = {full4, empty4, af4, ae4, of4, uf4};
            ex = {(i == 3), 1'b0, (i >= 2), (i == 0), 2'b00};
            checks++;
            if (fl !== ex || cnt4 !== 3'(i + 1)) begin
                errors++;
                $display("FAIL fill_%0d got flags %b cnt %0d want %b cnt %0d", i, fl, cnt4, ex,
                         i + 1);
            end
        end
    endtask

    task automatic test_overflow;
        drive4(1'b1, 1'b0, 16'h0001);
        checks++;
        if (of4 !== 1'b1 || cnt4 !== 3'd4 || full4 !== 1'b1) begin
            errors++; $display("FAIL overflow_pulse got of %b cnt %0d want 1/4", of4, cnt4);
        end
        drive4(1'b0, 1'b0, 16'h0000);
        checks++;
        if (of4 !== 1'b0 || cnt4 !== 3'd4) begin
            errors++; $display("FAIL overflow_clear got of %b cnt %0d want 0/4", of4, cnt4);
        end
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
            checks++;
            if (dout4 !== 16'(5 - i)) begin
                errors++; $display("FAIL drain_data_%0d got %h want %h", i, dout4, 16'(5 - i));
            end
`endif
            drive4(1'b0, 1'b1, 16'h0000);
`ifndef FIFO_FWFT_EN
            checks++;
            if (dout4 !== 16'(5 - i)) begin
                errors++; $display("FAIL drain_data_%0d got %h want %h", i, dout4, 16'(5 - i));
            end
`endif
            checks++;
            if (cnt4 !== 3'(3 - i) || uf4 !== 1'b0) begin
                errors++; $display("FAIL drain_cnt_%0d got %0d want %0d", i, cnt4, 3 - i);
            end
        end
        checks++;
        if (empty4 !== 1'b1 || ae4 !== 1'b1 || af4 !== 1'b0) begin
            errors++; $display("FAIL drain_empty got e %b ae %b af %b want 1/1/0", empty4, ae4, af4);
        end
    endtask

    task automatic test_underflow;
        logic [15:0] hold;
`ifdef FIFO_FWFT_EN
        hold = 16'h0000;
`else
        hold = 16'h0002;
`endif
        drive4(1'b0, 1'b1, 16'h0000);
        checks++;
        if (uf4 !== 1'b1 || cnt4 !== 3'd0 || dout4 !== hold) begin
            errors++;
            $display("FAIL underflow_pulse got uf %b cnt %0d data %h want 1/0/%h", uf4, cnt4,
                     dout4, hold);
        end
        drive4(1'b0, 1'b0, 16'h0000);
        checks++;
        if (uf4 !== 1'b0) begin
            errors++; $display("FAIL underflow_clear got %b want 0", uf4);
        end
        drive4(1'b1, 1'b1, 16'hAAAA);
        checks++;
        if (cnt4 !== 3'd1 || uf4 !== 1'b1 || of4 !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw got cnt %0d uf %b of %b want 1/1/0", cnt4, uf4, of4);
        end
`ifdef FIFO_FWFT_EN
        hold = 16'hAAAA;
`endif
        checks++;
        if (dout4 !== hold) begin
            errors++; $display("FAIL empty_rw_data got %h want %h", dout4, hold);
        end
        drive4(1'b0, 1'b1, 16'h0000);
`ifndef FIFO_FWFT_EN
        checks++;
        if (dout4 !== 16'hAAAA) begin
            errors++; $display("FAIL empty_rw_read got %h want aaaa", dout4);
        end
`endif
        checks++;
        if (cnt4 !== 3'd0) begin
            errors++; $display("FAIL empty_rw_cnt got %0d want 0", cnt4);
        end
    endtask

    task automatic test_full_rw;
        logic [15:0] exp_seq [4];
        exp_seq = '{16'h0011, 16'h0012, 16'h0013, 16'h1234};
        for (int i = 0; i < 4; i++) drive4(1'b1, 1'b0, 16'(16'h0010 + i));
`ifdef FIFO_FWFT_EN
        checks++;
        if (dout4 !== 16'h0010) begin
            errors++; $display("FAIL full_rw_head got %h want 0010", dout4);
        end
`endif
        drive4(1'b1, 1'b1, 16'h1234);
        checks++;
        if (cnt4 !== 3'd4 || of4 !== 1'b0 || full4 !== 1'b1) begin
            errors++; $display("FAIL full_rw got cnt %0d of %b want 4/0", cnt4, of4);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (dout4 !== 16'h0010) begin
            errors++; $display("FAIL full_rw_head got %h want 0010", dout4);
        end
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
            checks++;
            if (dout4 !== exp_seq[i]) begin
                errors++; $display("FAIL full_rw_seq_%0d got %h want %h", i, dout4, exp_seq[i]);
            end
`endif
            drive4(1'b0, 1'b1, 16'h0000);
`ifndef FIFO_FWFT_EN
            checks++;
            if (dout4 !== exp_seq[i]) begin
                errors++; $display("FAIL full_rw_seq_%0d got %h want %h", i, dout4, exp_seq[i]);
            end
`endif
        end
        checks++;
        if (cnt4 !== 3'd0) begin
            errors++; $display("FAIL full_rw_cnt got %0d want 0", cnt4);
        end
    endtask

    task automatic test_wrap;
        int  mcount, w_idx, r_idx;
        logic w, r;
        mcount = 0; w_idx = 0; r_idx = 0;
        for (int c = 0; c < 100 && r_idx < 12; c++) begin
            w = (w_idx < 12) && (mcount < 5) && (c % 3 != 2);
            r = (mcount > 0) && ((c % 2 == 1) || (w_idx == 12));
            wr5 = w; rd5 = r; din5 = 16'(w_idx);
`ifdef FIFO_FWFT_EN
            if (r) begin
                checks++;
                if (dout5 !== 16'(r_idx)) begin
                    errors++; $display("FAIL wrap_data_%0d got %h want %h", r_idx, dout5, r_idx);
                end
            end
`endif
            @(posedge clk); #1;
`ifndef FIFO_FWFT_EN
            if (r) begin
                checks++;
                if (dout5 !== 16'(r_idx)) begin
                    errors++; $display("FAIL wrap_data_%0d got %h want %h", r_idx, dout5, r_idx);
                end
            end
`endif
            if (w) w_idx++;
            if (r) r_idx++;
            mcount = mcount + (w ? 1 : 0) - (r ? 1 : 0);
            checks++;
            if (cnt5 !== 3'(mcount) || of5 !== 1'b0 || uf5 !== 1'b0) begin
                errors++; $display("FAIL wrap_cnt_c%0d got %0d want %0d", c, cnt5, mcount);
            end
        end
        wr5 = 1'b0; rd5 = 1'b0;
        checks++;
        if (r_idx != 12) begin
            errors++; $display("FAIL wrap_timeout got %0d reads want 12", r_idx);
        end
    endtask

    task automatic test_async_reset;
        logic [5:0] fl;
        for (int i = 0; i < 4; i++) drive4(1'b1, 1'b0, 16'(16'h0021 + i));
        drive4(1'b0, 1'b1, 16'h0000);
        checks++;
        if (cnt4 !== 3'd3) begin
            errors++; $display("FAIL areset_pre got cnt %0d want 3", cnt4);
        end
        #3 rst = 1'b0;
        #1;
        fl = {full4, empty4, af4, ae4, of4, uf4};
        checks++;
        if (fl !== 6'b010100 || cnt4 !== 3'd0 || dout4 !== 16'h0) begin
            errors++;
            $display("FAIL areset got flags %b cnt %0d data %h want 010100/0/0000", fl, cnt4,
                     dout4);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cnt4 !== 3'd0 || empty4 !== 1'b1) begin
            errors++; $display("FAIL areset_release got cnt %0d want 0", cnt4);
        end
        drive4(1'b1, 1'b0, 16'h00FF);
        checks++;
`ifdef FIFO_FWFT_EN
        if (dout4 !== 16'h00FF || cnt4 !== 3'd1) begin
            errors++; $display("FAIL fwft_show got %h cnt %0d want 00ff/1", dout4, cnt4);
        end
`else
        if (dout4 !== 16'h0000 || cnt4 !== 3'd1) begin
            errors++; $display("FAIL reg_no_read got %h cnt %0d want 0000/1", dout4, cnt4);
        end
`endif
    endtask

    initial begin
        checks = 0; errors = 0;
        wr4 = 1'b0; rd4 = 1'b0; din4 = '0;
        wr5 = 1'b0; rd5 = 1'b0; din5 = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
